// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
//
// Multi-cycle shifter for the execute stage. Performs SLL, SRL and SRA on an
// n-bit operand by a run-time amount, moving one bit position per clock. The
// control unit starts an operation with a start/done handshake; the result
// register B holds the final value from the done cycle until the next
// accepted start.
//
// Optional feature macro: SHIFT_ROL_EN
//   defined   : op=2'b11 performs rotate-left by one bit per step
//   undefined : op=2'b11 behaves exactly as SLL (no rotate logic built)
//
// Parameters
//   n    operand/result width (>= 2, power of two), default 32
//   SHW  shift-amount width, derived as $clog2(n)
//
// Ports
//   clk    in   1    rising-edge clock
//   rst_n  in   1    asynchronous active-low reset
//   start  in   1    request, sampled only while idle
//   op     in   2    00 SLL, 01 SRL, 10 SRA, 11 ROL/SLL
//   A      in   n    operand, sampled with start
//   shamt  in   SHW  shift amount 0..n-1, sampled with start
//   B      out  n    working/result register
//   busy   out  1    high whenever the unit is not idle
//   done   out  1    one-cycle pulse, B valid while high
// -----------------------------------------------------------------------------
module shift_unit #(
   parameter  int n   = 32,
   localparam int SHW = $clog2(n)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [n-1:0]   A,
   input  logic [SHW-1:0] shamt,
   output logic [n-1:0]   B,
   output logic           busy,
   output logic           done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_ROL_EN
   localparam logic [1:0] OP_ROL = 2'b11;
`endif

   state_t           r_state;
   logic [1:0]       r_op;
   logic [SHW-1:0]   r_cnt;
   logic [n-1:0]     r_b;
   logic             r_busy;
   logic             r_done;

   logic [n-1:0]     w_step;
   logic             w_last;

   // One-bit step of the working register for the latched operation.
   // Anything not decoded below (including op=11 when rotate is not built)
   // falls through to a logical left shift.
   function automatic logic [n-1:0] step_one(input logic [1:0]   f_op,
                                             input logic [n-1:0] f_b);
      logic [n-1:0] v;
      case (f_op)
         OP_SRL:  v = {1'b0, f_b[n-1:1]};
         OP_SRA:  v = {f_b[n-1], f_b[n-1:1]};
`ifdef SHIFT_ROL_EN
         OP_ROL:  v = {f_b[n-2:0], f_b[n-1]};
`endif
         OP_SLL:  v = {f_b[n-2:0], 1'b0};
         default: v = {f_b[n-2:0], 1'b0};
      endcase
      return v;
   endfunction

   assign w_step = step_one(r_op, r_b);
   // The shift performed while cnt==1 is the final one.
   assign w_last = (r_cnt == SHW'(1));

   // busy and done are registered alongside the state so they change only on
   // clock edges (or immediately on reset) and never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= 2'b00;
         r_cnt   <= '0;
         r_b     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_b    <= A;
                  r_op   <= op;
                  r_cnt  <= shamt;
                  r_busy <= 1'b1;
                  // A zero shift skips straight to the result cycle.
                  if (shamt == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_SHIFT;
                  end
               end else begin
                  r_busy <= 1'b0;
               end
            end

            S_SHIFT: begin
               r_b   <= w_step;
               r_cnt <= r_cnt - SHW'(1);
               if (w_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end

            S_DONE: begin
               // start is deliberately ignored here; the earliest new
               // request is taken in the following idle cycle.
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign B    = r_b;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_unit
//
// Self-checking bench for shift_unit. A behavioural model tracks how many
// busy cycles remain for the accepted request and the final result computed
// with whole-word shift operators; a negedge process compares busy, done and
// (whenever the result is meant to be stable) B against it. Directed cases
// pin the model with hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_shift_unit;

   localparam int N  = 32;
   localparam int SW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [N-1:0]  A = '0;
   logic [SW-1:0] shamt = '0;
   logic [N-1:0]  B;
   logic          busy;
   logic          done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   shift_unit #(.n(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .A     (A),
      .shamt (shamt),
      .B     (B),
      .busy  (busy),
      .done  (done)
   );

   task automatic check(input string name, input logic [N-1:0] act,
                        input logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Whole-word result of shifting a by k positions.
   function automatic logic [N-1:0] ref_shift(input logic [1:0] o,
                                              input logic [N-1:0] a,
                                              input int k);
      logic signed [N-1:0] s;
      s = a;
      case (o)
         2'b01: return a >> k;
         2'b10: return s >>> k;
         2'b11: begin
`ifdef SHIFT_ROL_EN
            if (k == 0) return a;
            return (a << k) | (a >> (N - k));
`else
            return a << k;
`endif
         end
         default: return a << k;
      endcase
   endfunction

   // Model: m_left = busy cycles still to come (0 = idle), m_b = result.
   int           m_left = 0;
   logic [N-1:0] m_b = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_b    = '0;
      end else if (m_left == 0) begin
         if (start) begin
            m_left = int'(shamt) + 1;
            m_b    = ref_shift(op, A, int'(shamt));
         end
      end else begin
         m_left--;
      end
   end

   always @(negedge clk) begin
      check("busy", {{(N-1){1'b0}}, busy}, {{(N-1){1'b0}}, (m_left > 0)});
      check("done", {{(N-1){1'b0}}, done}, {{(N-1){1'b0}}, (m_left == 1)});
      if (m_left <= 1) check("B", B, m_b);
   end

   task automatic sync();
      @(posedge clk);
      #2;
   endtask

   // Issue one request from idle, wait (bounded) for done, check the result
   // and the number of busy cycles against literals.
   task automatic run(input logic [1:0] o, input logic [N-1:0] a, input int k,
                      input logic [N-1:0] exp, input string name);
      int  nbusy;
      bit  seen;
      nbusy = 0;
      seen  = 1'b0;
      op    = o;
      A     = a;
      shamt = SW'(k);
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      for (int i = 0; i < N + 4; i++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check({name, "_done_seen"}, {{(N-1){1'b0}}, seen}, {{(N-1){1'b0}}, 1'b1});
      check({name, "_result"}, B, exp);
      check({name, "_busy_cycles"}, N'(nbusy), N'(k + 1));
      sync();
   endtask

   initial begin
      logic [N-1:0] rol_exp;
      int nd;

      // Reset held.
      repeat (3) @(posedge clk);
      #1;
      check("rst_B", B, '0);
      check("rst_busy", {{(N-1){1'b0}}, busy}, '0);
      check("rst_done", {{(N-1){1'b0}}, done}, '0);
      #1;
      rst_n = 1'b1;
      repeat (4) sync();

      run(2'b00, 32'h0000_0001, 31, 32'h8000_0000, "sll31");
      run(2'b10, 32'h8000_00F0, 4,  32'hF800_000F, "sra4");
      run(2'b01, 32'h8000_00F0, 4,  32'h0800_000F, "srl4");
      run(2'b00, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, "k0");
      run(2'b10, 32'hDEAD_BEEF, 31, 32'hFFFF_FFFF, "sra31");
`ifdef SHIFT_ROL_EN
      rol_exp = 32'h0000_0003;
`else
      rol_exp = 32'h0000_0002;
`endif
      run(2'b11, 32'h8000_0001, 1, rol_exp, "op11");

      // start pulsed during SHIFT with a different operand is ignored.
      op = 2'b00; A = 32'h0000_0001; shamt = SW'(10); start = 1'b1;
      sync();
      start = 1'b0;
      repeat (3) sync();
      A = 32'hFFFF_0000; shamt = SW'(2); op = 2'b01; start = 1'b1;
      sync();
      start = 1'b0;
      nd = 0;
      for (int i = 0; i < N + 4; i++) begin
         @(negedge clk);
         if (done) begin
            nd = 1;
            break;
         end
      end
      check("ign_done_seen", N'(nd), N'(1));
      check("ign_result", B, 32'h0000_0400);
      repeat (2) sync();

      // Reset in the middle of SHIFT: immediate clear, no done afterwards.
      op = 2'b01; A = 32'hA5A5_A5A5; shamt = SW'(20); start = 1'b1;
      sync();
      start = 1'b0;
      repeat (5) sync();
      rst_n = 1'b0;
      #1;
      check("midrst_B", B, '0);
      check("midrst_busy", {{(N-1){1'b0}}, busy}, '0);
      check("midrst_done", {{(N-1){1'b0}}, done}, '0);
      repeat (2) sync();
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("midrst_no_done", N'(nd), '0);
      sync();

      // start held high with shamt=0: one completion every two cycles.
      op = 2'b00; shamt = '0; start = 1'b1;
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         A = $urandom;
         @(negedge clk);
         if (done) nd++;
         @(posedge clk);
         #2;
      end
      start = 1'b0;
      check("b2b_done_count", N'(nd), N'(6));
      repeat (3) sync();

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 2) == 0);
         op    = 2'($urandom_range(0, 3));
         A     = $urandom;
         shamt = ($urandom_range(0, 3) == 0) ? SW'(N - 1) : SW'($urandom_range(0, N - 1));
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            sync();
            rst_n = 1'b1;
         end
         sync();
      end
      start = 1'b0;

      // Drain the last request (bounded).
      nd = 0;
      for (int i = 0; i < N + 4; i++) begin
         sync();
         if (!busy) begin
            nd = 1;
            break;
         end
      end
      check("drain_idle", N'(nd), N'(1));
      repeat (2) sync();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
